// File: rtl/imem_program_loader.sv
// Instruction-memory loader: receives a framed byte stream (length, words, XOR checksum)
// and writes each assembled 32-bit word into the instruction memory while holding the core.
module imem_program_loader #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [1:0]          idx_q;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         data_q;
  logic [7:0]          csum_q;
  logic [ADDR_W:0]     total_q, total_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                accept;
  logic                launch;
  logic                last_word;

  assign accept    = byte_valid & byte_ready;
  assign launch    = start & (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign last_word = ((cnt_q + CNT_ONE) == total_q);
  assign total_d   = (byte_in == 8'd0) ? DEPTH : (ADDR_W+1)'(byte_in);
  assign shift_d   = BIG_ENDIAN ? {shift_q[23:0], byte_in} : {byte_in, shift_q[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN:   if (accept) state_d = S_DATA;
      S_DATA:  if (accept && idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode the state register only, so none has a path from byte_valid.
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state_q)
      S_LEN, S_DATA, S_CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      S_DONE:  begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else if (launch) begin
      idx_q  <= '0;
      csum_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      case (state_q)
        S_LEN: if (accept) total_q <= total_d;
        S_DATA: if (accept) begin
          shift_q <= shift_d;
          csum_q  <= csum_q ^ byte_in;
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) data_q <= shift_d;
        end
        // A full-depth load lets the address wrap to 0 without writing there.
        S_WRITE: begin
          addr_q <= addr_q + ADDR_ONE;
          cnt_q  <= cnt_q + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: fixed frames, table-driven random frames,
// and hand-written sequences for reset, stalls, full depth and start-while-busy.
module tb_imem_program_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, start, byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready, wr_en, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  imem_program_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .word_count(word_count), .cpu_hold(cpu_hold)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  stream_q[$];
  logic [39:0] wlog[$];

  always @(negedge clk) if (wr_en) wlog.push_back({wr_addr, wr_data});

  typedef struct {
    int len;
    int stall_pct;
    bit bad_csum;
    bit exp_done;
    int exp_count;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " byte_ready"}, 64'(byte_ready), 64'(0));
    chk({tag, " wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, " wr_addr"}, 64'(wr_addr), 64'(0));
    chk({tag, " wr_data"}, 64'(wr_data), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " err"}, 64'(err), 64'(0));
    chk({tag, " word_count"}, 64'(word_count), 64'(0));
    chk({tag, " cpu_hold"}, 64'(cpu_hold), 64'(1));
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] b, cs;
    cs = 8'h00;
    stream_q.delete();
    stream_q.push_back(8'(n % 256));
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      cs ^= b;
      stream_q.push_back(b);
    end
    stream_q.push_back(corrupt ? ~cs : cs);
  endtask

  // Drives the whole of stream_q after a start pulse; byte_valid randomly drops
  // and garbage appears on byte_in while it is low.
  task automatic run_stream(input int stall_pct, input int mid_start_at);
    int i = 0;
    int cyc = 0;
    bit mid_done = 1'b0;
    wlog.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (i < stream_q.size() && cyc < 20000) begin
      start = 1'b0;
      if (i == mid_start_at && !mid_done) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      if ($urandom_range(99) < stall_pct) begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in = stream_q[i];
        if (byte_ready) i++;
      end
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (cyc >= 20000) begin
      bad++;
      $display("FAIL stream_timeout: consumed %0d of %0d bytes", i, stream_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Reference: interpret the frame directly and compare the write log and final status.
  task automatic check_model(input string tag);
    int n;
    logic [7:0] cs;
    logic [31:0] w;
    bit good;
    n = (stream_q[0] == 8'd0) ? 256 : int'(stream_q[0]);
    cs = 8'h00;
    for (int k = 0; k < 4 * n; k++) cs ^= stream_q[1 + k];
    good = (stream_q[1 + 4 * n] == cs);
    chk({tag, " writes"}, 64'(wlog.size()), 64'(n));
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      w = {stream_q[1 + 4*i], stream_q[2 + 4*i], stream_q[3 + 4*i], stream_q[4 + 4*i]};
      chk({tag, " wlog"}, 64'(wlog[i]), 64'({8'(i), w}));
    end
    chk({tag, " done"}, 64'(done), 64'(good));
    chk({tag, " err"}, 64'(err), 64'(!good));
    chk({tag, " cpu_hold"}, 64'(cpu_hold), 64'(!good));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " byte_ready"}, 64'(byte_ready), 64'(0));
    chk({tag, " word_count"}, 64'(word_count), 64'(n));
    chk({tag, " wr_addr"}, 64'(wr_addr), 64'(n % 256));
  endtask

  task automatic load_two_word(input logic [7:0] csum);
    stream_q.delete();
    stream_q = '{8'h02, 8'h8C, 8'h00, 8'h00, 8'h05, 8'h40, 8'h01, 8'h00, 8'h02, csum};
  endtask

  task automatic check_two_word(input string tag, input bit exp_ok);
    chk({tag, " writes"}, 64'(wlog.size()), 64'(2));
    if (wlog.size() >= 2) begin
      chk({tag, " w0"}, 64'(wlog[0]), 64'({8'h00, 32'h8C000005}));
      chk({tag, " w1"}, 64'(wlog[1]), 64'({8'h01, 32'h40010002}));
    end
    chk({tag, " word_count"}, 64'(word_count), 64'(2));
    chk({tag, " done"}, 64'(done), 64'(exp_ok));
    chk({tag, " err"}, 64'(err), 64'(!exp_ok));
    chk({tag, " cpu_hold"}, 64'(cpu_hold), 64'(!exp_ok));
  endtask

  initial begin
    int n0;
    logic [7:0] rb[5];
    tbl[0] = '{len: 1, stall_pct: 0,  bad_csum: 1'b0, exp_done: 1'b1, exp_count: 1};
    tbl[1] = '{len: 3, stall_pct: 30, bad_csum: 1'b0, exp_done: 1'b1, exp_count: 3};
    tbl[2] = '{len: 5, stall_pct: 60, bad_csum: 1'b1, exp_done: 1'b0, exp_count: 5};
    tbl[3] = '{len: 4, stall_pct: 20, bad_csum: 1'b0, exp_done: 1'b1, exp_count: 4};
    tbl[4] = '{len: 7, stall_pct: 45, bad_csum: 1'b1, exp_done: 1'b0, exp_count: 7};

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #1;
    check_reset_outputs("por");
    #20;
    @(negedge clk);
    rst = 1'b0;

    load_two_word(8'hCA);
    run_stream(0, -1);
    check_two_word("two_word", 1'b1);

    load_two_word(8'h00);
    run_stream(0, -1);
    check_two_word("bad_csum", 1'b0);

    load_two_word(8'hCA);
    run_stream(50, -1);
    check_two_word("stall", 1'b1);

    for (int r = 0; r < 5; r++) begin
      build_random(tbl[r].len, tbl[r].bad_csum);
      run_stream(tbl[r].stall_pct, -1);
      check_model($sformatf("vec%0d", r));
      chk($sformatf("vec%0d tbl_done", r), 64'(done), 64'(tbl[r].exp_done));
      chk($sformatf("vec%0d tbl_count", r), 64'(word_count), 64'(tbl[r].exp_count));
    end

    stream_q.delete();
    stream_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      stream_q.push_back(8'h00); stream_q.push_back(8'h00);
      stream_q.push_back(8'h00); stream_q.push_back(8'(i));
    end
    stream_q.push_back(8'h00);
    run_stream(10, -1);
    check_model("full");
    chk("full word_count", 64'(word_count), 64'(256));
    chk("full wrap", 64'(wr_addr), 64'(0));
    chk("full done", 64'(done), 64'(1));

    stream_q.delete();
    stream_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_stream(0, 2);
    chk("busy_start writes", 64'(wlog.size()), 64'(1));
    if (wlog.size() >= 1) chk("busy_start w0", 64'(wlog[0]), 64'({8'h00, 32'hDEADBEEF}));
    chk("busy_start done", 64'(done), 64'(1));

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("relaunch cpu_hold", 64'(cpu_hold), 64'(1));
    chk("relaunch done", 64'(done), 64'(0));
    chk("relaunch busy", 64'(busy), 64'(1));
    chk("relaunch word_count", 64'(word_count), 64'(0));

    rb = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 5; k++) begin
      byte_valid = 1'b1;
      byte_in = rb[k];
      @(negedge clk);
    end
    byte_in = 8'h55;
    chk("latency wr_en", 64'(wr_en), 64'(1));
    chk("latency wr_data", 64'(wr_data), 64'(32'h11223344));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    n0 = wlog.size();
    repeat (3) @(negedge clk);
    chk("rst no_writes", 64'(wlog.size()), 64'(n0));
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst idle ready", 64'(byte_ready), 64'(0));
    chk("post_rst busy", 64'(busy), 64'(0));
    chk("post_rst cpu_hold", 64'(cpu_hold), 64'(1));
    chk("post_rst wr_en", 64'(wr_en), 64'(0));
    byte_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the 32x256 instruction memory. The core only reads that memory; this block fills it.
- Accepts a framed byte stream (length header, big-endian instruction words, XOR checksum) over a valid/ready handshake.
- Writes each assembled word through the memory's write port (wea/addra/dina).
- Holds the core stalled until a load completes with a good checksum.

Parameters:
- ADDR_W, 8, instruction memory address width; depth is 2**ADDR_W words.
- BIG_ENDIAN, 1, 1: first byte of a word goes to [31:24]; 0: first byte goes to [7:0].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write enable (wea).
- wr_addr  out  ADDR_W  instruction memory address (addra).
- wr_data  out  32  instruction memory write data (dina).
- busy  out  1  load in progress.
- done  out  1  last load succeeded; held until next start or reset.
- err  out  1  last load failed its checksum; held until next start or reset.
- word_count  out  ADDR_W+1  words written in the current or last load.
- cpu_hold  out  1  core must not fetch or advance while this is high.

Behaviour:
- Reset is asynchronous and active-high. While rst is high, and immediately on its assertion:
  - state=IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, done=0, err=0, word_count=0, cpu_hold=1.
  - Byte index, remaining count and checksum accumulator all cleared.
- A byte transfers only on a posedge with byte_valid=1 and byte_ready=1. byte_ready is a registered function of state only; it never depends on byte_valid.
- States:
  - IDLE: byte_ready=0. start -> LEN; on that edge clear word_count, wr_addr, checksum, done, err, and set busy=1.
  - LEN: byte_ready=1. Accepted byte N sets the word total; N=0 means 2**ADDR_W words. The length byte is not part of the checksum. -> DATA.
  - DATA: byte_ready=1. Shift each accepted byte into the word assembly register per BIG_ENDIAN and XOR it into the checksum. On the 4th byte, load wr_data with the completed word -> WRITE.
  - WRITE: exactly one cycle. wr_en=1, byte_ready=0, wr_addr = current word index.
    - Next edge: wr_addr += 1 and word_count += 1.
    - If word_count now equals the word total -> CSUM; else -> DATA.
    - When the total is 2**ADDR_W, wr_addr wraps to 0 after the last write; there is no write at the wrapped address.
  - CSUM: byte_ready=1. Accepted byte equals the accumulator -> DONE with done=1. Otherwise -> ERR with err=1. Either way busy=0.
  - DONE: byte_ready=0, cpu_hold=0. start -> LEN with cpu_hold=1 from that edge.
  - ERR: byte_ready=0, cpu_hold=1. start -> LEN.
- cpu_hold=1 in every state except DONE. Memory contents after ERR are partially written and must not be executed.
- start while busy (LEN/DATA/WRITE/CSUM) is ignored.
- byte_valid with byte_ready=0 is not consumed; the source must hold the byte.
- Stalls of any length in byte_valid are tolerated; there is no timeout.
- Write latency: wr_en rises on the edge that accepts the 4th byte of a word. Minimum word period is 5 cycles (4 accept + 1 write).
- Reset mid-load: wr_en drops asynchronously. No partial write may complete after reset asserts.
- wr_en is high only in WRITE.

Test Plan:
- Reset with traffic active: assert rst during DATA -> all outputs at reset values in the same cycle, state IDLE, cpu_hold=1, no further wr_en pulses.
- Two-word load, BIG_ENDIAN=1:
  - Stream: start, then 02, 8C 00 00 05, 40 01 00 02, checksum (8C^05^40^01^02=CA).
  - Expect wr_en pulses at addr 0 with 8C000005 and at addr 1 with 40010002.
  - Expect word_count=2, done=1, cpu_hold=0, err=0.
- Bad checksum: same stream with checksum 00 -> err=1, done=0, cpu_hold stays 1, both words still written.
- Backpressure/stall: byte_valid toggled 1-0-0-1 randomly mid-word -> each word's wr_data is unchanged versus the unstalled stream, and exactly one wr_en per word.
- Full depth: length byte 00, 1024 data bytes (word i = i), correct checksum -> 256 writes at addr 0..255, word_count=256, wr_addr wraps to 0, done=1.
- start ignored while busy: pulse start during DATA of a 1-word load -> load completes normally with a single word written, then a start in DONE relaunches with cpu_hold=1 and done=0.
